// File: rtl/demux7_pkg.sv
// demux7_pkg: shared types and sizing constants for the demux7_collect block.
// Optional parity beat is enabled by the macro DEMUX7_PARITY_EN.
package demux7_pkg;

    localparam int DEMUX7_WIDTH = 7;
    localparam int DEMUX7_SEL_W = 3;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Even-parity bit of a word of up to 8 slots (unused upper bits are zero).
    function automatic logic even_parity8(input logic [7:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/demux7_collect_if.sv
// demux7_collect_if: write/handshake bus and parallel word outputs of demux7_collect.
// The parity_err signal exists only when DEMUX7_PARITY_EN is defined.
interface demux7_collect_if
    import demux7_pkg::*;
#(
    parameter int WIDTH = DEMUX7_WIDTH,
    parameter int SEL_W = DEMUX7_SEL_W
) ();

    logic             data_in;
    logic [SEL_W-1:0] sel;
    logic             wr_valid;
    logic             wr_ready;
    logic             auto_mode;
    logic             clr;
    logic             word_ack;
    logic [WIDTH-1:0] out_word;
    logic             word_valid;
    logic             err_sel;
`ifdef DEMUX7_PARITY_EN
    logic             parity_err;

    modport master (
        output data_in, sel, wr_valid, auto_mode, clr, word_ack,
        input  wr_ready, out_word, word_valid, err_sel, parity_err
    );

    modport slave (
        input  data_in, sel, wr_valid, auto_mode, clr, word_ack,
        output wr_ready, out_word, word_valid, err_sel, parity_err
    );
`else
    modport master (
        output data_in, sel, wr_valid, auto_mode, clr, word_ack,
        input  wr_ready, out_word, word_valid, err_sel
    );

    modport slave (
        input  data_in, sel, wr_valid, auto_mode, clr, word_ack,
        output wr_ready, out_word, word_valid, err_sel
    );
`endif

endinterface

// File: rtl/demux7_onehot.sv
// demux7_onehot: combinational address-to-one-hot slot decoder with an
// out-of-range flag. Shared by the explicit (sel) and auto (ptr) write paths.
module demux7_onehot #(
    parameter int WIDTH  = 7,
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [WIDTH-1:0]  onehot_o,
    output logic              oor_o
);

    // Decode the address into one slot strobe; flag addresses past the last slot.
    always_comb begin
        onehot_o = '0;
        oor_o    = (addr_i >= ADDR_W'(WIDTH));
        for (int i = 0; i < WIDTH; i++) begin
            if (addr_i == ADDR_W'(i)) begin
                onehot_o[i] = 1'b1;
            end else begin
                onehot_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux7_collect.sv
// demux7_collect: routes a serial bit into one of WIDTH registered slots,
// either by explicit select or by an internal pointer that assembles a full
// word and holds it until acknowledged.
// Optional feature macro: DEMUX7_PARITY_EN (adds an even-parity beat after the
// last slot in auto mode and a sticky parity_err output).
module demux7_collect
    import demux7_pkg::*;
#(
    parameter int WIDTH = DEMUX7_WIDTH,
    parameter int SEL_W = DEMUX7_SEL_W
) (
    input  logic             clock,
    input  logic             resetn,
    demux7_collect_if.slave  bus
);

    // One extra address bit so the pointer can reach the parity beat index
    // (WIDTH) even when WIDTH == 2**SEL_W.
    localparam int ADDR_W = SEL_W + 1;
`ifdef DEMUX7_PARITY_EN
    localparam int LAST_BEAT = WIDTH;
`else
    localparam int LAST_BEAT = WIDTH - 1;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              mode_q, mode_d;
    logic              err_sel_q, err_sel_d;
`ifdef DEMUX7_PARITY_EN
    logic              parity_err_q, parity_err_d;
    logic [7:0]        word_ext_s;
`endif

    logic              wr_ready_s;
    logic              wr_fire_s;
    logic              eff_mode_s;
    logic [ADDR_W-1:0] addr_s;
    logic [WIDTH-1:0]  slot_oh_s;
    logic              oor_s;
    logic [WIDTH-1:0]  word_wr_s;

    assign wr_ready_s = (state_q == COLLECT);
    assign wr_fire_s  = bus.wr_valid & wr_ready_s;
    // The mode is only re-sampled at a word boundary; the live input applies
    // to the first write of a word so it needs no extra setup cycle.
    assign eff_mode_s = ((state_q == COLLECT) && (ptr_q == '0)) ? bus.auto_mode : mode_q;
    assign addr_s     = eff_mode_s ? ptr_q : {1'b0, bus.sel};
    assign word_wr_s  = (word_q & ~slot_oh_s) | (slot_oh_s & {WIDTH{bus.data_in}});
`ifdef DEMUX7_PARITY_EN
    assign word_ext_s = 8'(word_q);
`endif

    demux7_onehot #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_onehot (
        .addr_i   (addr_s),
        .onehot_o (slot_oh_s),
        .oor_o    (oor_s)
    );

    // Next-state logic: clear first, then per-state write/ack handling.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        word_d    = word_q;
        mode_d    = mode_q;
        err_sel_d = err_sel_q;
`ifdef DEMUX7_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (bus.clr) begin
            state_d   = COLLECT;
            ptr_d     = '0;
            word_d    = '0;
            mode_d    = bus.auto_mode;
            err_sel_d = 1'b0;
`ifdef DEMUX7_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    mode_d = eff_mode_s;
                    if (wr_fire_s) begin
                        if (eff_mode_s) begin
                            // Parity beat address is out of range, so no slot changes.
                            word_d = word_wr_s;
`ifdef DEMUX7_PARITY_EN
                            if (ptr_q == ADDR_W'(WIDTH)) begin
                                parity_err_d = parity_err_q |
                                               (bus.data_in != even_parity8(word_ext_s));
                            end else begin
                                parity_err_d = parity_err_q;
                            end
`endif
                            if (ptr_q == ADDR_W'(LAST_BEAT)) begin
                                ptr_d   = '0;
                                state_d = FULL;
                            end else begin
                                ptr_d = ptr_q + ADDR_W'(1);
                            end
                        end else begin
                            ptr_d = '0;
                            if (oor_s) begin
                                err_sel_d = 1'b1;
                            end else begin
                                word_d = word_wr_s;
                            end
                        end
                    end else begin
                        word_d = word_q;
                    end
                end
                FULL: begin
                    if (bus.word_ack) begin
                        state_d = COLLECT;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    // State, pointer, word and sticky flag registers with async reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= COLLECT;
            ptr_q     <= '0;
            word_q    <= '0;
            mode_q    <= 1'b0;
            err_sel_q <= 1'b0;
`ifdef DEMUX7_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            word_q    <= word_d;
            mode_q    <= mode_d;
            err_sel_q <= err_sel_d;
`ifdef DEMUX7_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.wr_ready   = wr_ready_s;
    assign bus.out_word   = word_q;
    assign bus.word_valid = (state_q == FULL);
    assign bus.err_sel    = err_sel_q;
`ifdef DEMUX7_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_demux7_collect.sv
// tb_demux7_collect: table-driven explicit-mode vectors plus hand-written
// auto-mode, backpressure, clear/ack collision and async-reset sequences.
module tb_demux7_collect;
    import demux7_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    demux7_collect_if bus ();

    demux7_collect dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clr;
        logic       am;
        logic       wv;
        logic       din;
        logic [2:0] sel;
        logic       ack;
        logic [6:0] ew;
        logic       evld;
        logic       erdy;
        logic       eerr;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input string nm, input logic c, input logic am,
                                input logic wv, input logic d, input logic [2:0] s,
                                input logic ak, input logic [6:0] ew, input logic ev,
                                input logic er, input logic ee);
        vec_t v;
        v.name = nm; v.clr = c; v.am = am; v.wv = wv; v.din = d; v.sel = s;
        v.ack = ak; v.ew = ew; v.evld = ev; v.erdy = er; v.eerr = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [6:0] ew, input logic ev,
                             input logic er, input logic ee);
        check({name, ".word"},  32'(bus.out_word),   32'(ew));
        check({name, ".valid"}, 32'(bus.word_valid), 32'(ev));
        check({name, ".ready"}, 32'(bus.wr_ready),   32'(er));
        check({name, ".err"},   32'(bus.err_sel),    32'(ee));
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0;
        bus.clr      = 1'b0;
        bus.word_ack = 1'b0;
        bus.data_in  = 1'b0;
        bus.sel      = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One auto-mode write; auto_mode input is whatever the caller passes.
    task automatic wr(input logic d, input logic am, input logic [2:0] s);
        bus.wr_valid  = 1'b1;
        bus.data_in   = d;
        bus.auto_mode = am;
        bus.sel       = s;
        step();
        bus.wr_valid  = 1'b0;
    endtask

    // Full auto word, bit0 first; writes 4..6 use late_am on auto_mode with sel=0.
    task automatic auto_word(input logic [6:0] bits, input logic late_am, input logic pbit);
        for (int i = 0; i < 7; i++) begin
            wr(bits[i], (i >= 4) ? late_am : 1'b1, 3'd0);
        end
`ifdef DEMUX7_PARITY_EN
        wr(pbit, 1'b1, 3'd0);
`else
        if (pbit) begin
            bus.auto_mode = 1'b1;
        end else begin
            bus.auto_mode = 1'b1;
        end
`endif
    endtask

    initial begin
        logic [6:0] w;
        bus.auto_mode = 1'b0;
        idle();

        // Reset state while resetn is held low.
        #3;
        check_all("reset", 7'b0000000, 1'b0, 1'b1, 1'b0);
`ifdef DEMUX7_PARITY_EN
        check("reset.parity_err", 32'(bus.parity_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0]  = mk("ex_sel0",    1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 7'b0000001, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mk("ex_sel3",    1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 7'b0001001, 1'b0, 1'b1, 1'b0);
        tbl[2]  = mk("ex_sel6",    1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 7'b1001001, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk("ex_hold",    1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 7'b1001001, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mk("ex_sel3_0",  1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 7'b1000001, 1'b0, 1'b1, 1'b0);
        tbl[5]  = mk("ex_sel7",    1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 7'b1000001, 1'b0, 1'b1, 1'b1);
        tbl[6]  = mk("err_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'b1000001, 1'b0, 1'b1, 1'b1);
        tbl[7]  = mk("ack_ignore", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 7'b1000001, 1'b0, 1'b1, 1'b1);
        tbl[8]  = mk("clr",        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000000, 1'b0, 1'b1, 1'b0);
        tbl[9]  = mk("clr_vs_wr",  1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 7'b0000000, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk("no_valid",   1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 7'b0000000, 1'b0, 1'b1, 1'b0);
        tbl[11] = mk("ex_sel1",    1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 7'b0000010, 1'b0, 1'b1, 1'b0);
        tbl[12] = mk("clr2",       1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 13; i++) begin
            bus.clr       = tbl[i].clr;
            bus.auto_mode = tbl[i].am;
            bus.wr_valid  = tbl[i].wv;
            bus.data_in   = tbl[i].din;
            bus.sel       = tbl[i].sel;
            bus.word_ack  = tbl[i].ack;
            step();
            check_all(tbl[i].name, tbl[i].ew, tbl[i].evld, tbl[i].erdy, tbl[i].eerr);
        end
        idle();

        // Auto word 1,0,1,1,0,0,1 with auto_mode dropped mid-word (must be ignored).
        w = 7'b1001101;
        auto_word(w, 1'b0, ^w);
        check_all("auto_full", 7'b1001101, 1'b1, 1'b0, 1'b0);

        // Extra write while FULL is refused.
        wr(1'b0, 1'b1, 3'd0);
        check_all("full_refuse", 7'b1001101, 1'b1, 1'b0, 1'b0);

        // Acknowledge: back to COLLECT, word kept.
        bus.word_ack = 1'b1;
        step();
        bus.word_ack = 1'b0;
        check_all("ack", 7'b1001101, 1'b0, 1'b1, 1'b0);

        // Next word overwrites slot 0 first.
        wr(1'b0, 1'b1, 3'd0);
        check_all("overwrite0", 7'b1001100, 1'b0, 1'b1, 1'b0);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;

        // clr together with word_ack in FULL.
        w = 7'b0000010;
        auto_word(w, 1'b1, ^w);
        check_all("auto_full2", 7'b0000010, 1'b1, 1'b0, 1'b0);
        bus.clr      = 1'b1;
        bus.word_ack = 1'b1;
        step();
        idle();
        check_all("clr_vs_ack", 7'b0000000, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset after 4 auto writes.
        for (int i = 0; i < 4; i++) begin
            wr(1'b1, 1'b1, 3'd0);
        end
        check_all("partial", 7'b0001111, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 7'b0000000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        w = 7'b1000011;
        auto_word(w, 1'b1, ^w);
        check_all("after_rst", 7'b1000011, 1'b1, 1'b0, 1'b0);

`ifdef DEMUX7_PARITY_EN
        // Wrong parity beat sets the sticky flag, FULL still reached.
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        auto_word(7'b0000011, 1'b1, 1'b1);
        check_all("par_bad", 7'b0000011, 1'b1, 1'b0, 1'b0);
        check("par_bad.parity_err", 32'(bus.parity_err), 32'd1);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check("par_clr.parity_err", 32'(bus.parity_err), 32'd0);
        auto_word(7'b0000011, 1'b1, 1'b0);
        check_all("par_good", 7'b0000011, 1'b1, 1'b0, 1'b0);
        check("par_good.parity_err", 32'(bus.parity_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
